// File: rtl/im_loader_pkg.sv
// Shared types and default constants for the boot-time instruction loader.
package im_loader_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned IM_DEPTH_DEF       = 256;
  localparam int unsigned ADDR_W_DEF         = 8;
  localparam int unsigned RELEASE_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/im_loader.sv
// Streams host instruction words into instruction memory, then releases core reset.
// Optional checksum-terminated images: define IM_LOADER_CHECKSUM_EN.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned IM_DEPTH       = IM_DEPTH_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_START,
  input  logic              in_VALID,
  input  logic [WORD_W-1:0] in_DATA,
  input  logic              in_LAST,
  output logic              out_READY,
  output logic              out_im_WE,
  output logic [ADDR_W-1:0] out_im_ADDR,
  output logic [WORD_W-1:0] out_im_DATA,
  output logic              out_core_RESET,
  output logic              out_DONE,
  output logic              out_ERROR
);

  localparam int unsigned       REL_W     = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0]  REL_INIT  = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IM_DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [REL_W-1:0]  timer;
  logic              ready_q;
  logic              xfer;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`endif

  // A start pulse takes priority, so no word is accepted in that cycle.
  assign out_READY = ready_q & ~in_START;
  assign xfer      = in_VALID & out_READY;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state          <= ST_IDLE;
      count          <= '0;
      timer          <= '0;
      ready_q        <= 1'b0;
      out_im_WE      <= 1'b0;
      out_im_ADDR    <= '0;
      out_im_DATA    <= '0;
      out_core_RESET <= 1'b1;
      out_DONE       <= 1'b0;
      out_ERROR      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      out_im_WE <= 1'b0;
      if (in_START) begin
        state          <= ST_LOAD;
        count          <= '0;
        ready_q        <= 1'b1;
        out_core_RESET <= 1'b1;
        out_DONE       <= 1'b0;
        out_ERROR      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        sum            <= '0;
`endif
      end else begin
        case (state)
          ST_LOAD: begin
            if (xfer) begin
`ifdef IM_LOADER_CHECKSUM_EN
              // The last word carries the expected sum and is never written.
              if (in_LAST) begin
                ready_q <= 1'b0;
                if (in_DATA == sum) begin
                  state <= ST_RELEASE;
                  timer <= REL_INIT;
                end else begin
                  state     <= ST_ERR;
                  out_ERROR <= 1'b1;
                end
              end else begin
                out_im_WE   <= 1'b1;
                out_im_ADDR <= count;
                out_im_DATA <= in_DATA;
                sum         <= sum + in_DATA;
                if (count == LAST_ADDR) begin
                  state     <= ST_ERR;
                  ready_q   <= 1'b0;
                  out_ERROR <= 1'b1;
                end else begin
                  count <= count + ADDR_W'(1);
                end
              end
`else
              out_im_WE   <= 1'b1;
              out_im_ADDR <= count;
              out_im_DATA <= in_DATA;
              if (in_LAST) begin
                state   <= ST_RELEASE;
                ready_q <= 1'b0;
                timer   <= REL_INIT;
              end else if (count == LAST_ADDR) begin
                // Image too large: keep the top word, never wrap to address 0.
                state     <= ST_ERR;
                ready_q   <= 1'b0;
                out_ERROR <= 1'b1;
              end else begin
                count <= count + ADDR_W'(1);
              end
`endif
            end
          end
          ST_RELEASE: begin
            if (timer == '0) begin
              state          <= ST_RUN;
              out_core_RESET <= 1'b0;
              out_DONE       <= 1'b1;
            end else begin
              timer <= timer - REL_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomized directed bench for im_loader; expected writes derived from the image contents.
module tb_im_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned RC    = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          CLK;
  logic          RESET;
  logic          in_START;
  logic          in_VALID;
  logic [31:0]   in_DATA;
  logic          in_LAST;
  logic          out_READY;
  logic          out_im_WE;
  logic [AW-1:0] out_im_ADDR;
  logic [31:0]   out_im_DATA;
  logic          out_core_RESET;
  logic          out_DONE;
  logic          out_ERROR;

  int  vectors     = 0;
  int  miscompares = 0;
  wr_t wlog[$];

  im_loader #(.IM_DEPTH(DEPTH), .ADDR_W(AW), .RELEASE_CYCLES(RC)) dut (
    .CLK(CLK), .RESET(RESET), .in_START(in_START), .in_VALID(in_VALID),
    .in_DATA(in_DATA), .in_LAST(in_LAST), .out_READY(out_READY),
    .out_im_WE(out_im_WE), .out_im_ADDR(out_im_ADDR), .out_im_DATA(out_im_DATA),
    .out_core_RESET(out_core_RESET), .out_DONE(out_DONE), .out_ERROR(out_ERROR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  // Log every write strobe seen in the memory interface.
  always @(negedge CLK) begin
    if (out_im_WE === 1'b1) wlog.push_back({out_im_ADDR, out_im_DATA});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge CLK);
    check({tag, "_ready"}, 64'(out_READY), 64'(0));
    check({tag, "_we"}, 64'(out_im_WE), 64'(0));
    check({tag, "_addr"}, 64'(out_im_ADDR), 64'(0));
    check({tag, "_data"}, 64'(out_im_DATA), 64'(0));
    check({tag, "_core_reset"}, 64'(out_core_RESET), 64'(1));
    check({tag, "_done"}, 64'(out_DONE), 64'(0));
    check({tag, "_error"}, 64'(out_ERROR), 64'(0));
    next_cycle();
  endtask

  // Start pulse (a valid word offered alongside must be refused), then one LOAD cycle.
  task automatic start_load();
    in_START = 1'b1;
    in_VALID = 1'b1;
    in_DATA  = $urandom;
    in_LAST  = 1'($urandom_range(0, 1));
    @(negedge CLK);
    check("start_ready", 64'(out_READY), 64'(0));
    next_cycle();
    in_START = 1'b0;
    in_VALID = 1'b0;
    @(negedge CLK);
    check("load_done_clear", 64'(out_DONE), 64'(0));
    check("load_core_reset", 64'(out_core_RESET), 64'(1));
    check("load_error_clear", 64'(out_ERROR), 64'(0));
    check("load_ready", 64'(out_READY), 64'(1));
    next_cycle();
  endtask

  task automatic feed(input logic [31:0] words[$], input bit mark_last);
    for (int i = 0; i < words.size(); i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_VALID = 1'b0;
        in_LAST  = 1'($urandom_range(0, 1));
        in_DATA  = $urandom;
        @(negedge CLK);
        check("gap_ready", 64'(out_READY), 64'(1));
        next_cycle();
      end
      in_VALID = 1'b1;
      in_DATA  = words[i];
      in_LAST  = mark_last && (i == words.size() - 1);
      @(negedge CLK);
      check("xfer_ready", 64'(out_READY), 64'(1));
      next_cycle();
    end
    in_VALID = 1'b0;
    in_LAST  = 1'b0;
  endtask

  // Core reset must stay high for exactly RC cycles after the last transfer.
  task automatic wait_release();
    int n;
    n = 0;
    @(negedge CLK);
    while (out_core_RESET === 1'b1 && n < 50) begin
      check("release_done_low", 64'(out_DONE), 64'(0));
      n++;
      @(negedge CLK);
    end
    check("release_cycles", 64'(n), 64'(RC));
    check("run_done", 64'(out_DONE), 64'(1));
    check("run_core_reset", 64'(out_core_RESET), 64'(0));
    check("run_error", 64'(out_ERROR), 64'(0));
    next_cycle();
  endtask

  task automatic check_log(input string tag, input wr_t exp[$]);
    @(negedge CLK);
    next_cycle();
    check({tag, "_count"}, 64'(wlog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < wlog.size(); i++)
      check(tag, 64'(wlog[i]), 64'(exp[i]));
    wlog.delete();
  endtask

  // Words the host sends for a program (checksum appended when that mode is built).
  task automatic make_words(input logic [31:0] prog[$], output logic [31:0] words[$]);
    logic [31:0] s;
    s = '0;
    words = prog;
`ifdef IM_LOADER_CHECKSUM_EN
    foreach (prog[i]) s += prog[i];
    words.push_back(s);
`endif
  endtask

  task automatic make_writes(input logic [31:0] prog[$], input wr_t pre[$], output wr_t exp[$]);
    wr_t w;
    exp = pre;
    foreach (prog[i]) begin
      w.addr = AW'(i);
      w.data = prog[i];
      exp.push_back(w);
    end
  endtask

  task automatic run_image(input string tag, input logic [31:0] prog[$], input wr_t pre[$]);
    logic [31:0] words[$];
    wr_t         exp[$];
    make_words(prog, words);
    feed(words, 1'b1);
    wait_release();
    make_writes(prog, pre, exp);
    check_log(tag, exp);
  endtask

  task automatic load_and_check(input string tag, input logic [31:0] prog[$]);
    wr_t none[$];
    wlog.delete();
    start_load();
    run_image(tag, prog, none);
  endtask

  task automatic host_ignored(input string tag, input logic exp_core_reset, input logic exp_done);
    wr_t none[$];
    repeat (3) begin
      in_VALID = 1'b1;
      in_DATA  = $urandom;
      in_LAST  = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check({tag, "_ready"}, 64'(out_READY), 64'(0));
      check({tag, "_core_reset"}, 64'(out_core_RESET), 64'(exp_core_reset));
      check({tag, "_done"}, 64'(out_DONE), 64'(exp_done));
      next_cycle();
    end
    in_VALID = 1'b0;
    in_LAST  = 1'b0;
    check_log({tag, "_writes"}, none);
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] prog2[$];
    logic [31:0] words[$];
    wr_t         pre[$];
    wr_t         exp[$];
    wr_t         none[$];
    int          n;

    RESET    = 1'b0;
    in_START = 1'b0;
    in_VALID = 1'b0;
    in_LAST  = 1'b0;
    in_DATA  = '0;
    next_cycle();
    next_cycle();
    check_reset_vals("reset");
    RESET = 1'b1;

    host_ignored("idle", 1'b1, 1'b0);

    prog = '{32'h11111111, 32'h22222222, 32'h33333333};
    load_and_check("basic", prog);
    host_ignored("run", 1'b0, 1'b1);

    prog = '{$urandom};
    load_and_check("single", prog);

    for (int k = 0; k < 6; k++) begin
`ifdef IM_LOADER_CHECKSUM_EN
      n = $urandom_range(0, DEPTH - 1);
`else
      n = $urandom_range(1, DEPTH);
`endif
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      load_and_check("random", prog);
    end

    // Overflow: DEPTH words without a last marker, then one more offered.
    wlog.delete();
    start_load();
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    feed(prog, 1'b0);
    in_VALID = 1'b1;
    in_DATA  = $urandom;
    repeat (3) begin
      @(negedge CLK);
      check("ovf_ready", 64'(out_READY), 64'(0));
      check("ovf_error", 64'(out_ERROR), 64'(1));
      check("ovf_core_reset", 64'(out_core_RESET), 64'(1));
      check("ovf_done", 64'(out_DONE), 64'(0));
      next_cycle();
    end
    in_VALID = 1'b0;
    make_writes(prog, none, exp);
    check_log("overflow", exp);

    prog = '{$urandom, $urandom};
    load_and_check("after_error", prog);

    // Restart mid-load: two words, start again, then a one-word image.
    wlog.delete();
    start_load();
    prog = '{$urandom, $urandom};
    feed(prog, 1'b0);
    make_writes(prog, none, pre);
    start_load();
    prog2 = '{32'hAAAA0000};
    run_image("restart", prog2, pre);

    // Abort a release in progress by starting a new load.
    wlog.delete();
    start_load();
    prog = '{$urandom, $urandom, $urandom};
    make_words(prog, words);
    feed(words, 1'b1);
    next_cycle();
    make_writes(prog, none, pre);
    start_load();
    prog2 = '{$urandom, $urandom};
    run_image("abort_release", prog2, pre);

    // Reset asserted in the same cycle a word is offered.
    wlog.delete();
    start_load();
    prog = '{$urandom};
    feed(prog, 1'b0);
    make_writes(prog, none, pre);
    RESET    = 1'b0;
    in_VALID = 1'b1;
    in_DATA  = $urandom;
    next_cycle();
    RESET    = 1'b1;
    in_VALID = 1'b0;
    check_reset_vals("midreset");
    check_log("midreset", pre);
    prog = '{$urandom, $urandom, $urandom};
    load_and_check("after_reset", prog);

`ifdef IM_LOADER_CHECKSUM_EN
    wlog.delete();
    start_load();
    words = '{32'd1, 32'd2, 32'd3};
    feed(words, 1'b1);
    wait_release();
    prog = '{32'd1, 32'd2};
    make_writes(prog, none, exp);
    check_log("csum_good", exp);

    start_load();
    words = '{32'd1, 32'd2, 32'd4};
    feed(words, 1'b1);
    @(negedge CLK);
    check("csum_bad_error", 64'(out_ERROR), 64'(1));
    check("csum_bad_core_reset", 64'(out_core_RESET), 64'(1));
    check("csum_bad_ready", 64'(out_READY), 64'(0));
    next_cycle();
    check_log("csum_bad", exp);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time instruction loader sitting directly upstream of the processor top.
- Accepts a valid/ready stream of 32-bit instruction words from a host or test source and writes them into instruction memory through the processor's im_WE/im_DATA path.
- Holds the processor's core resets (pc, rb, tf, dm, pipeline registers) asserted until loading completes plus a fixed settle window, then releases the core to run.

Parameters:
- IM_DEPTH, 256, number of instruction-memory words; loads beyond this are an error.
- ADDR_W, 8, width of the word address; must satisfy 2**ADDR_W >= IM_DEPTH.
- RELEASE_CYCLES, 4, cycles core reset stays asserted after the last write (minimum 1).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-low reset.
- in_START  in  1  one-cycle pulse; begins or restarts a load.
- in_VALID  in  1  host word valid.
- in_DATA  in  32  host instruction word.
- in_LAST  in  1  marks the final word of the image; qualified by in_VALID.
- out_READY  out  1  loader accepts in_DATA this cycle.
- out_im_WE  out  1  instruction-memory write strobe.
- out_im_ADDR  out  ADDR_W  word address of the write.
- out_im_DATA  out  32  write data.
- out_core_RESET  out  1  active-high reset to the core's pc/im-read/rb/tf/dm/pipeline resets.
- out_DONE  out  1  image loaded and core released.
- out_ERROR  out  1  sticky error (overflow, or checksum mismatch when the optional feature is enabled).

Behaviour:
- Reset (RESET=0 at a CLK edge) forces:
  - state IDLE, address counter 0;
  - out_READY=0, out_im_WE=0, out_im_ADDR=0, out_im_DATA=0;
  - out_core_RESET=1, out_DONE=0, out_ERROR=0.
- A transfer occurs when in_VALID && out_READY on a rising edge.
- States:
  - IDLE:
    - out_READY=0; core held in reset.
    - in_START -> LOAD with address counter cleared.
  - LOAD:
    - out_READY=1 except in a cycle where in_START=1.
    - Each transfer produces registered out_im_WE=1, out_im_ADDR=counter, out_im_DATA=in_DATA on the next cycle (1-cycle latency), then the counter increments.
    - out_im_WE is 0 in every cycle without a preceding transfer.
    - Transfer with in_LAST=1 -> RELEASE.
  - RELEASE:
    - out_READY=0; counts RELEASE_CYCLES cycles with out_core_RESET=1.
    - Then -> RUN.
    - The final write strobe lands in the first RELEASE cycle.
  - RUN:
    - out_core_RESET=0, out_DONE=1, out_READY=0; host data ignored.
    - in_START -> LOAD: core reset re-asserted and out_DONE cleared in the next cycle, counter to 0.
  - ERR:
    - out_ERROR=1, out_READY=0, out_core_RESET=1.
    - Only in_START (-> LOAD, clears out_ERROR) or RESET exits.
- Overflow: a transfer while counter==IM_DEPTH-1 without in_LAST writes the word at IM_DEPTH-1, then -> ERR. No wrap-around write to address 0.
- in_START in LOAD restarts the load:
  - counter to 0;
  - in_VALID is not accepted that cycle;
  - a pending write strobe from the previous cycle still completes.
- in_START in IDLE, LOAD, RUN or ERR has the same effect. In RELEASE it aborts the release -> LOAD.
- Single-word image (first transfer has in_LAST=1) is legal: one write at address 0.
- Mid-operation reset discards the counter and any pending write strobe.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Defined:
  - a 32-bit running sum (mod 2^32) of all written words is kept;
  - the word transferred with in_LAST is a checksum and is NOT written;
  - in_LAST while still in LOAD is compared against the running sum: equal -> RELEASE, mismatch -> ERR;
  - the sum clears on entry to LOAD;
  - an in_LAST transfer with no prior words compares against 0.
- Undefined: the in_LAST word is an ordinary instruction and is written; no sum logic is present.

Decomposition:
- Package im_loader_pkg: state encoding (IDLE, LOAD, RELEASE, RUN, ERR), default parameter constants, the 32-bit instruction word width.
- No sub-module: counter, release timer and checksum are small enough to stay inline in one FSM module.

Test Plan:
- Basic load:
  - Stimulus: after reset, in_START, then 3 words 0x11111111, 0x22222222, 0x33333333 (last with in_LAST).
  - Response: writes at addresses 0, 1, 2 with matching data; out_core_RESET stays 1 for 4 cycles after the last write, then 0 with out_DONE=1.
- Back-pressure and gaps:
  - Stimulus: in_VALID toggled 1/0/1.
  - Response: exactly one write per transfer; no write strobe in gap cycles; in IDLE, out_READY=0 and no writes.
- Overflow:
  - Stimulus: IM_DEPTH=4, 5 words without in_LAST.
  - Response: writes at 0..3, then out_ERROR=1, out_READY=0, core reset held; in_START clears the error.
- Restart mid-load:
  - Stimulus: 2 words, then in_START, then 1 word with in_LAST=0xAAAA0000.
  - Response: final write is at address 0; core released after RELEASE_CYCLES.
- Reset mid-load:
  - Stimulus: RESET=0 for one cycle during LOAD.
  - Response: all outputs at reset values next cycle; no pending write emitted.
- Checksum (IM_LOADER_CHECKSUM_EN):
  - Stimulus: words 1, 2, then in_LAST word 3.
  - Response: writes at 0, 1 only, then released.
  - Repeat with checksum 4: out_ERROR=1.
